// File: rtl/alu_pkg.sv
// Shared types for the ALU command path: opcodes, flag bundle and the
// queued command record.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic zero;
    } alu_flags_t;

    typedef struct packed {
        alu_op_e    op;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
    } alu_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Registered command FIFO feeding the issue stage.
// Push is ignored when full and pop is ignored when empty.
module cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_cmd_t wdata,
    input  logic     pop,
    output alu_cmd_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    alu_cmd_t      mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage needs no reset: contents are only read while count is nonzero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Buffers ALU commands, issues one per cycle to the combinational ALU and
// captures result/flags into a handshaked response slot with accumulator.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_use_acc,
    output logic [2:0]       alu_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [7:0]       acc,
    output logic             ovf_sticky,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

    alu_cmd_t   wcmd;
    alu_cmd_t   head;
    alu_flags_t flags_q;
    logic       full;
    logic       empty;
    logic       push;
    logic       cap;

    assign wcmd = '{op:      alu_op_e'(cmd_op),
                    a:       cmd_a,
                    b:       cmd_b,
                    use_acc: cmd_use_acc};

    // Ready depends only on registered occupancy, never on cmd_valid.
    assign cmd_ready = rst_n && !full;
    assign push      = cmd_valid && cmd_ready;
    assign cap       = !empty && (!rsp_valid || rsp_ready);

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wcmd),
        .pop   (cap),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        if (!empty) begin
            alu_op = head.op;
            alu_a  = head.use_acc ? acc : head.a;
            alu_b  = head.b;
        end
    end

    assign rsp_flags = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            flags_q    <= '0;
            acc        <= '0;
            op_count   <= '0;
        end else if (cap) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            flags_q    <= '{overflow: alu_overflow,
                            carry:    alu_carry,
                            zero:     alu_zero};
            acc        <= alu_result;
            if (op_count != '1) begin
                op_count <= op_count + 1'b1;
            end
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // A same-cycle clear wins over a new overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end else if (cap && alu_overflow) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Command-buffering front end that sits directly upstream of the 8-bit combinational ALU. It accepts ALU commands over a valid/ready interface and queues them in a small FIFO. One command per cycle is issued to the ALU, optionally substituting an internal accumulator for operand A. The ALU result and flags are captured into a registered response slot with its own valid/ready handshake, which also maintains the accumulator, a sticky overflow flag and a completed-operation counter.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- CNT_W, 16, width of completed-operation counter
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept a command
- cmd_op  in  3  ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 SHR)
- cmd_a, cmd_b  in  8 each  operands, two's complement
- cmd_use_acc  in  1  replace cmd_a with accumulator at issue time
- alu_op  out  3  to ALU op_sel
- alu_a, alu_b  out  8 each  to ALU operands
- alu_result  in  8  from ALU, combinational on alu_*
- alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags
- rsp_valid  out  1  response slot holds a result
- rsp_ready  in  1  consumer takes response
- rsp_result  out  8  captured result
- rsp_flags  out  3  {overflow, carry, zero} captured
- acc  out  8  accumulator (last captured result)
- ovf_sticky  out  1  set on any captured overflow
- clr_sticky  in  1  synchronous clear of ovf_sticky
- op_count  out  CNT_W  completed operations, saturating

## Operation
- Push: cmd_valid && cmd_ready writes {op, a, b, use_acc} at write pointer.
- cmd_ready = (count != DEPTH); independent of same-cycle pop; forced 0 while rst_n low.
- Issue (combinational): alu_op/alu_b from FIFO head; alu_a = head.use_acc ? acc : head.a. With FIFO empty, alu_* drive 0.
- Capture condition: cap = !empty && (!rsp_valid || rsp_ready).
- On cap: rsp_result ← alu_result; rsp_flags ← {alu_overflow, alu_carry, alu_zero}; rsp_valid ← 1; acc ← alu_result; pop head; op_count += 1 (holds at all-ones).
- ovf_sticky ← 1 on cap with alu_overflow. clr_sticky has priority: if both occur in the same cycle, ovf_sticky ends at 0.
- rsp_valid && rsp_ready && !cap clears rsp_valid. rsp_* are stable while rsp_valid && !rsp_ready.
- Simultaneous push and pop: count unchanged, pointers both advance, wrap modulo DEPTH.
- Reset (async, any time, including mid-stream): FIFO flushed (count = 0, pointers 0), rsp_valid = 0, rsp_result = 0, rsp_flags = 0, acc = 0, ovf_sticky = 0, op_count = 0. Pending commands and any unconsumed response are discarded.

## Timing
- Command accepted at edge T is visible at the head no earlier than after edge T (registered FIFO). It is captured at edge T+1 at the earliest, and rsp_valid is high in cycle T+1 to T+2. Minimum latency: 2 edges.
- Throughput is 1 command per cycle with rsp_ready held high.
- Dependent chains (use_acc = 1) back-to-back: the acc update and the pop share an edge, so the next head sees the new acc with no bubble.
- Backpressure: rsp_ready low with rsp_valid high stalls capture. The FIFO fills, and cmd_ready drops in the cycle count reaches DEPTH.
- No combinational path from cmd_valid to cmd_ready. rsp_ready → (cap, pop) is combinational within the block.

## Structure
- Shared package alu_pkg: alu_op_e enum (8 opcodes above), alu_flags_t packed struct {overflow, carry, zero}, alu_cmd_t packed struct {op, a, b, use_acc}.
- Sub-module cmd_fifo (parameter DEPTH, data type alu_cmd_t): push/pop/full/empty/count.
- Issue mux, response slot, acc, sticky and counter live in alu_issue_unit.

## Test plan
- Reset: rst_n low mid-burst with 3 queued commands → all outputs 0, cmd_ready 0 while reset is held, 1 after release; no response appears.
- Single ADD 0x7F+0x01, rsp_ready = 1 → rsp_result 0x80, rsp_flags 3'b100, ovf_sticky 1, op_count 1, rsp_valid 2 edges after accept.
- Accumulator chain: SUB 0x05−0x05, then ADD use_acc b = 0x03, then SHL use_acc, streamed back-to-back → results 0x00 (flags 001), 0x03, 0x06 on consecutive cycles, acc = 0x06.
- Backpressure: rsp_ready = 0, push 6 commands → 4 accepted after the first is captured to the slot (5 held total), cmd_ready low. Release rsp_ready → all 5 responses drain in order, 1 per cycle.
- Simultaneous push/pop at count = 3, DEPTH = 4, pointer wrap → count stays 3, order preserved across wrap.
- clr_sticky asserted in the same cycle as an overflowing capture → ovf_sticky 0. Preset op_count to all-ones via 65535 ops → stays at 0xFFFF.
